firebird7_in_gate1_tessent_tdr_w3: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_TDR_W3 -- requirements
Module: firebird7_in_gate1_tessent_tdr_w3

---
 rtl/firebird7_in_gate1_tessent_tdr_pkg.sv | 27 ++
 rtl/firebird7_in_gate1_tessent_tdr_parity.sv | 16 +
 rtl/firebird7_in_gate1_tessent_tdr_w3.sv | 98 +++++++++
 tb/tb_firebird7_in_gate1_tessent_tdr_w3.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// rtl/firebird7_in_gate1_tessent_tdr_pkg.sv - shared defaults, chain length and enable priority decode for the IJTAG TDR
package firebird7_in_gate1_tessent_tdr_pkg;

    localparam int TDR_WIDTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,
        OP_CAPTURE = 2'd1,
        OP_SHIFT   = 2'd2,
        OP_UPDATE  = 2'd3
    } tdr_op_e;

    function automatic int chain_len(input int width, input bit parity_en);
        return parity_en ? width + 2 : width + 1;
    endfunction

    // Capture wins over shift, shift over update; nothing happens while deselected.
    function automatic tdr_op_e decode_op(input logic sel, input logic ce,
                                          input logic se, input logic ue);
        if (!sel)    return OP_IDLE;
        else if (ce) return OP_CAPTURE;
        else if (se) return OP_SHIFT;
        else if (ue) return OP_UPDATE;
        else         return OP_IDLE;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_parity.sv
// rtl/firebird7_in_gate1_tessent_tdr_parity.sv - even-parity generation on capture and chain check on update
module firebird7_in_gate1_tessent_tdr_parity
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int WIDTH = TDR_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   capture_fields,
    input  logic [WIDTH+1:0] chain,
    output logic             capture_parity,
    output logic             chain_ok
);

    assign capture_parity = ^capture_fields;
    assign chain_ok       = ~(^chain);

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w3.sv
// rtl/firebird7_in_gate1_tessent_tdr_w3.sv - IJTAG TDR driving a downstream mux select/data; parity via FIREBIRD7_IN_TDR_PARITY_EN
module firebird7_in_gate1_tessent_tdr_w3
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int              WIDTH      = TDR_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             update_error
);

`ifdef FIREBIRD7_IN_TDR_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int L = chain_len(WIDTH, PARITY_EN);

    logic [L-1:0]     sr_q, sr_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [L-1:0]     capture_vec;
    logic             upd_ok;
    tdr_op_e          op;

    assign op = decode_op(ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue);

`ifdef FIREBIRD7_IN_TDR_PARITY_EN
    logic cap_par;

    firebird7_in_gate1_tessent_tdr_parity #(
        .WIDTH (WIDTH)
    ) u_parity (
        .capture_fields (({sel_q, functional_data_in})),
        .chain          (sr_q),
        .capture_parity (cap_par),
        .chain_ok       (upd_ok)
    );

    assign capture_vec = {sel_q, functional_data_in, cap_par};
`else
    assign upd_ok      = 1'b1;
    assign capture_vec = {sel_q, functional_data_in};
`endif

    always_comb begin
        sr_d   = sr_q;
        sel_d  = sel_q;
        data_d = data_q;
        err_d  = err_q;
        unique case (op)
            OP_CAPTURE: sr_d = capture_vec;
            OP_SHIFT:   sr_d = {ijtag_si, sr_q[L-1:1]};
            OP_UPDATE: begin
                // A rejected chain leaves the mux controls untouched and flags it.
                if (upd_ok) begin
                    sel_d  = sr_q[L-1];
                    data_d = sr_q[L-2 -: WIDTH];
                    err_d  = 1'b0;
                end else begin
                    err_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr_q   <= '0;
            sel_q  <= 1'b0;
            data_q <= RESET_DATA;
            err_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign ijtag_so       = sr_q[0];
    assign ijtag_select   = sel_q;
    assign ijtag_data_out = data_q;
    assign update_error   = err_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3.sv
// tb/tb_firebird7_in_gate1_tessent_tdr_w3.sv - scoreboard bench for the IJTAG TDR, WIDTH=3
module tb_firebird7_in_gate1_tessent_tdr_w3;

    logic       ijtag_tck = 1'b0;
    logic       ijtag_reset;
    logic       ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
    logic       ijtag_so;
    logic [2:0] functional_data_in;
    logic       ijtag_select;
    logic [2:0] ijtag_data_out;
    logic       update_error;
    bit         clk_en = 1'b1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       sel;
        logic [2:0] data;
        logic       err;
        logic       so;
    } exp_t;

    exp_t exp_q[$];
    event chk_now;

    firebird7_in_gate1_tessent_tdr_w3 #(
        .WIDTH      (3),
        .RESET_DATA (3'b000)
    ) dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_sel          (ijtag_sel),
        .ijtag_ce           (ijtag_ce),
        .ijtag_se           (ijtag_se),
        .ijtag_ue           (ijtag_ue),
        .ijtag_si           (ijtag_si),
        .ijtag_so           (ijtag_so),
        .functional_data_in (functional_data_in),
        .ijtag_select       (ijtag_select),
        .ijtag_data_out     (ijtag_data_out),
        .update_error       (update_error)
    );

    always #5 if (clk_en) ijtag_tck = ~ijtag_tck;

    initial begin
        forever begin
            @(negedge ijtag_tck or chk_now);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (ijtag_select !== e.sel || ijtag_data_out !== e.data ||
                    update_error !== e.err || ijtag_so !== e.so) begin
                    bad++;
                    $display("FAIL %s: got sel=%b data=%b err=%b so=%b, want sel=%b data=%b err=%b so=%b",
                             e.name, ijtag_select, ijtag_data_out, update_error, ijtag_so,
                             e.sel, e.data, e.err, e.so);
                end
            end
        end
    end

    task automatic push(input string name, input logic sel, input logic [2:0] data,
                        input logic err, input logic so);
        exp_t e;
        e.name = name; e.sel = sel; e.data = data; e.err = err; e.so = so;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic s, input logic ce, input logic se,
                        input logic ue, input logic si);
        ijtag_sel = s; ijtag_ce = ce; ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
        @(posedge ijtag_tck);
        #1;
        ijtag_sel = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0;
    endtask

    initial begin
        logic [4:0] bits;
        ijtag_reset = 1'b0;
        ijtag_sel = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
        functional_data_in = 3'b000;
        #3;
        push("reset_state", 1'b0, 3'b000, 1'b0, 1'b0);
        -> chk_now;
        @(negedge ijtag_tck);
        ijtag_reset = 1'b1;
        @(negedge ijtag_tck);

`ifndef FIREBIRD7_IN_TDR_PARITY_EN
        // Shift 1,0,1,1 then update: select=1, data=101
        bits = 5'b01101;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0, bits[i]);
            push("shift_a", 1'b0, 3'b000, 1'b0, (i == 3) ? 1'b1 : 1'b0);
        end
        step(1, 0, 0, 1, 0);
        push("update_a", 1'b1, 3'b101, 1'b0, 1'b1);

        // Capture {1,110} and unload: so = 0,1,1,1 then 0
        functional_data_in = 3'b110;
        step(1, 1, 0, 0, 0);
        push("capture_so0", 1'b1, 3'b101, 1'b0, 1'b0);
        bits = 5'b00111;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0, 0);
            push("unload_so", 1'b1, 3'b101, 1'b0, bits[i]);
        end

        // Load chain 1001, then deselected activity must change nothing
        bits = 5'b01001;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0, bits[i]);
            push("shift_b", 1'b1, 3'b101, 1'b0, (i == 3) ? 1'b1 : 1'b0);
        end
        functional_data_in = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 1, 0);
            push("sel0_hold", 1'b1, 3'b101, 1'b0, 1'b1);
        end
        step(1, 0, 0, 1, 0);
        push("update_after_hold", 1'b1, 3'b001, 1'b0, 1'b1);

        // se and ue together: shift 1001 -> 0100, outputs hold
        step(1, 0, 1, 1, 0);
        push("se_ue_shift", 1'b1, 3'b001, 1'b0, 1'b0);
        step(1, 0, 0, 1, 0);
        push("update_c", 1'b0, 3'b100, 1'b0, 1'b0);

        // All enables: capture {0,011}
        functional_data_in = 3'b011;
        step(1, 1, 1, 1, 1);
        push("ce_se_ue_capture", 1'b0, 3'b100, 1'b0, 1'b1);
        step(1, 0, 0, 1, 0);
        push("update_d", 1'b0, 3'b011, 1'b0, 1'b1);
`else
        // Odd chain 11010 rejected
        bits = 5'b11010;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, bits[i]);
            push("par_shift_a", 1'b0, 3'b000, 1'b0, 1'b0);
        end
        step(1, 0, 0, 1, 0);
        push("par_reject", 1'b0, 3'b000, 1'b1, 1'b0);

        // Even chain 11011 accepted
        bits = 5'b11011;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, bits[i]);
        end
        push("par_shift_b", 1'b0, 3'b000, 1'b1, 1'b1);
        step(1, 0, 0, 1, 0);
        push("par_accept", 1'b1, 3'b101, 1'b0, 1'b1);

        // Capture {1,011,p=1} = 10111 and unload
        functional_data_in = 3'b011;
        step(1, 1, 0, 0, 0);
        push("par_capture", 1'b1, 3'b101, 1'b0, 1'b1);
        bits = 5'b01011;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0, 0);
            push("par_unload", 1'b1, 3'b101, 1'b0, bits[i]);
        end
        step(1, 0, 0, 1, 0);
        push("par_reject_b", 1'b1, 3'b101, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1, 0);
            push("par_sel0_hold", 1'b1, 3'b101, 1'b1, 1'b1);
        end
`endif

        // Reset mid-shift with the clock stopped
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        @(negedge ijtag_tck);
        clk_en = 1'b0;
        #2;
        ijtag_sel = 1'b1; ijtag_se = 1'b1; ijtag_si = 1'b1;
        ijtag_reset = 1'b0;
        #1;
        push("async_reset", 1'b0, 3'b000, 1'b0, 1'b0);
        -> chk_now;
        #2;
        clk_en = 1'b1;
        // Update attempted while reset is held must not take effect
        step(1, 0, 0, 1, 1);
        push("update_in_reset", 1'b0, 3'b000, 1'b0, 1'b0);
        @(negedge ijtag_tck);
        ijtag_reset = 1'b1;

        repeat (4) @(negedge ijtag_tck);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
